serial_frame_receiver: RTL

- Receive end of the inter-board serial link; the transmitting board drives clkIn/dataIn on its GPIO, and this block drives readyForReceive back.
- Synchronises the remote serial clock and data into the local clock domain and shifts in a WIDTH-bit frame, MSB first.
- Presents the completed frame to the local consumer (game-board logic / Nios PIO) with a valid/ack handshake, and throttles the sender via readyForReceive.

---
 rtl/serial_frame_receiver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// Receive end of the inter-board serial link: synchronises the remote clkIn/dataIn,
// shifts in a WIDTH-bit frame MSB first and hands it to the local consumer via valid/ack.
module serial_frame_receiver #(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clkIn,
    input  logic             dataIn,
    output logic             readyForReceive,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic [CNT_W-1:0] bit_count,
    output logic             frame_err,
    output logic             ovr_err
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_s3;
    logic             r_dat_s1;
    logic             r_dat_s2;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_ready;
    logic [CNT_W-1:0] r_bit_count;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_frame_err;
    logic             r_ovr_err;

    logic             w_edge;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH:0]   w_sh_cat;
    logic [WIDTH-1:0] w_sh_next;

    // Two-flop synchronisers plus a history flop on clkIn for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_s3 <= 1'b0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
        end else begin
            r_clk_s1 <= clkIn;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= dataIn;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_edge    = r_clk_s2 & ~r_clk_s3;
    assign w_shift   = w_edge && (r_state == S_IDLE || r_state == S_RECV);
    // bit_count is 0 in IDLE, so this also covers the WIDTH==1 case straight from IDLE.
    assign w_last    = (r_bit_count == CNT_LAST);
    assign w_sh_cat  = {r_sh, r_dat_s2};
    assign w_sh_next = w_sh_cat[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_ready     <= 1'b1;
            r_bit_count <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_ovr_err   <= 1'b0;
            if (w_shift) begin
                r_sh     <= w_sh_next;
                r_to_cnt <= '0;
                if (w_last) begin
                    r_rx_data   <= w_sh_next;
                    r_rx_valid  <= 1'b1;
                    r_ready     <= 1'b0;
                    r_bit_count <= '0;
                    r_state     <= S_DONE;
                end else begin
                    r_bit_count <= r_bit_count + CNT_ONE;
                    r_state     <= S_RECV;
                end
            end else begin
                case (r_state)
                    S_RECV: begin
                        // A stalled sender abandons the partial frame; sh is left as is.
                        if (r_to_cnt == TO_MAX) begin
                            r_frame_err <= 1'b1;
                            r_bit_count <= '0;
                            r_to_cnt    <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_ONE;
                        end
                    end
                    S_DONE: begin
                        // An edge here is never shifted, even when ack frees the buffer.
                        if (w_edge) begin
                            r_ovr_err <= 1'b1;
                        end
                        if (rx_ack) begin
                            r_rx_valid <= 1'b0;
                            r_ready    <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: begin
                        r_to_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign readyForReceive = r_ready;
    assign rx_data         = r_rx_data;
    assign rx_valid        = r_rx_valid;
    assign bit_count       = r_bit_count;
    assign frame_err       = r_frame_err;
    assign ovr_err         = r_ovr_err;

endmodule
